prog_fetch: RTL
===============

// Module: prog_fetch
// PURPOSE
//  Instruction fetch stage of the RAT MCU. It sits directly upstream of the 1024x18 synchronous program ROM.
//  It owns the program counter, drives the ROM address, and pairs the ROM word returned one clock later with its address.
//  It delivers a valid instruction per cycle to the decoder, and handles stall, jump, call, return and interrupt redirects.
//  It contains a hardware return-address stack (RAS).
// PARAMETERS
//  ADDR_W     10      program address width (ROM depth 2**ADDR_W)
//  INSTR_W    18      instruction width
//  RESET_VEC  10'h000 first fetch address after reset; also the target of a RET on an empty stack
//  INTR_VEC   10'h3FF interrupt vector
//  RAS_DEPTH  8       return-address stack entries (power of 2)
// PORTS
//  CLK        in   1        system clock, rising edge
//  RST_N      in   1        reset, asynchronous, active-low
//  PROG_ADDR  out  ADDR_W   ROM address (ROM registers rom[PROG_ADDR] at CLK edge)
//  PROG_IR    in   INSTR_W  ROM data, one cycle after address
//  IR         out  INSTR_W  instruction to decoder; 0 when IR_VALID=0
//  IR_VALID   out  1        IR/IR_PC valid
//  IR_PC      out  ADDR_W   address of IR
//  STALL      in   1        decoder hold; ignored when IR_VALID=0
//  REDIR      in   1        redirect request, sampled only when IR_VALID=1
//  REDIR_SEL  in   2        00 JUMP, 01 CALL, 10 RET, 11 INTR
//  REDIR_ADDR in   ADDR_W   JUMP/CALL target
//  RAS_COUNT  out  $clog2(RAS_DEPTH)+1  stack occupancy
//  STK_ERR    out  1        sticky overflow/underflow flag, cleared only by reset
// BEHAVIOUR
//  Reset (async, RST_N=0):
//   - F_PC=RESET_VEC, so PROG_ADDR=RESET_VEC.
//   - IR_VALID=0, IR=0, IR_PC=0, RAS_COUNT=0, STK_ERR=0, state=BOOT.
//   - Asserting reset mid-stall or mid-redirect applies these values immediately.
//  FSM:
//   - BOOT -> RUN unconditionally.
//   - RUN -> SQUASH on REDIR; RUN stays RUN otherwise.
//   - SQUASH -> RUN unconditionally.
//   - IR_VALID = (state==RUN).
//  Addressing:
//   - PROG_ADDR = (RUN & STALL & !REDIR) ? IR_PC : F_PC. The ROM re-reads the held word, so IR is stable during a stall.
//   - Normal advance, at the edge in BOOT or in RUN without stall: IR_PC<=F_PC, then F_PC<=F_PC+1 mod 2**ADDR_W (0x3FF -> 0x000).
//   - Stall: F_PC and IR_PC hold. There is no gap after release.
//  Redirect (RUN, REDIR=1; REDIR has priority over STALL):
//   - F_PC<=target. The word already issued is squashed.
//   - Latency: 1 bubble cycle; the target word is valid 2 cycles after the REDIR edge.
//   - JUMP: target=REDIR_ADDR.
//   - CALL: push IR_PC+1 (wraps); target=REDIR_ADDR.
//   - RET: pop; target=popped value.
//   - INTR: push IR_PC (the instruction was not executed); target=INTR_VEC.
//  RAS:
//   - Circular LIFO.
//   - Push when full: overwrite the oldest entry, RAS_COUNT stays RAS_DEPTH, STK_ERR<=1.
//   - Pop when empty: target=RESET_VEC, RAS_COUNT stays 0, STK_ERR<=1.
//   - Push and pop never occur in the same cycle (exclusive by REDIR_SEL).
// STRUCTURE
//  - prog_fetch_pkg: redir_sel_t enum (JUMP, CALL, RET, INTR), fetch_state_t enum (BOOT, RUN, SQUASH), default vector constants.
//  - Sub-module ret_addr_stack: push/pop, data in/out, count, ovf/unf pulses.
//  - The FSM, PC and address mux stay in prog_fetch.
// TESTING (ROM model preloaded rom[i]=i+18'h100, 1-cycle read)
//  1. Release RST_N, no stall.
//     -> Cycle 1: PROG_ADDR=0, IR_VALID=0.
//     -> Cycle 2: IR=0x100, IR_PC=0.
//     -> Afterwards IR_PC increments every cycle.
//  2. STALL=1 for 3 cycles at IR_PC=5.
//     -> IR=0x105, IR_PC=5, PROG_ADDR=5 held throughout.
//     -> Next cycle after release: IR_PC=6.
//  3. JUMP to 0x200 at IR_PC=3.
//     -> 1 cycle with IR_VALID=0.
//     -> Then IR_PC=0x200, IR=0x300.
//  4. CALL 0x040 at IR_PC=0x010, then RET at IR_PC=0x041.
//     -> Resumes at IR_PC=0x011.
//     -> RAS_COUNT goes 1 -> 0.
//     -> Also: sequential fetch from 0x3FF continues at 0x000.
//  5. INTR at IR_PC=0x020.
//     -> After the bubble, IR_PC=0x3FF.
//     -> JUMP 0x050, then RET: resumes at 0x020.
//  6. Nine CALLs (depth 8).
//     -> STK_ERR=1, RAS_COUNT=8.
//     -> Nine RETs: the ninth targets RESET_VEC.
//     -> RST_N pulsed mid-stall clears all state asynchronously.

Source files
------------

// File: rtl/prog_fetch_pkg.sv
// Shared types and default vectors for the RAT MCU fetch stage.
// Imported by the fetch top, its RAS and the bus interface.
package prog_fetch_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int INSTR_W_DEF   = 18;
  localparam int RAS_DEPTH_DEF = 8;

  localparam logic [9:0] RESET_VEC_DEF = 10'h000;
  localparam logic [9:0] INTR_VEC_DEF  = 10'h3FF;

  typedef enum logic [1:0] {
    SEL_JUMP = 2'b00,
    SEL_CALL = 2'b01,
    SEL_RET  = 2'b10,
    SEL_INTR = 2'b11
  } redir_sel_t;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_SQUASH
  } fetch_state_t;

endpackage

// File: rtl/prog_fetch_if.sv
// Fetch bundle: ROM port, decoder handshake, redirect and RAS status.
// master = fetch stage, slave = ROM/decoder side.
interface prog_fetch_if
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = $clog2(RAS_DEPTH_DEF) + 1
);

  logic [ADDR_W-1:0]  PROG_ADDR;
  logic [INSTR_W-1:0] PROG_IR;
  logic [INSTR_W-1:0] IR;
  logic               IR_VALID;
  logic [ADDR_W-1:0]  IR_PC;
  logic               STALL;
  logic               REDIR;
  logic [1:0]         REDIR_SEL;
  logic [ADDR_W-1:0]  REDIR_ADDR;
  logic [CNT_W-1:0]   RAS_COUNT;
  logic               STK_ERR;

  modport master (
    output PROG_ADDR, IR, IR_VALID, IR_PC,
    output RAS_COUNT, STK_ERR,
    input  PROG_IR, STALL, REDIR,
    input  REDIR_SEL, REDIR_ADDR
  );

  modport slave (
    input  PROG_ADDR, IR, IR_VALID, IR_PC,
    input  RAS_COUNT, STK_ERR,
    output PROG_IR, STALL, REDIR,
    output REDIR_SEL, REDIR_ADDR
  );

endinterface

// File: rtl/prog_fetch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest.
// Pop data is combinational from the current top entry.
module ret_addr_stack
  import prog_fetch_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int W     = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rp    = wp_q - PW'(1);
  assign dout  = mem_q[rp];
  assign count = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (push) begin
      mem_d[wp_q] = din;
      wp_d        = wp_q + PW'(1);
      if (full) ovf   = 1'b1;
      else      cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      if (empty) begin
        unf = 1'b1;
      end else begin
        wp_d  = rp;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_fetch.sv
// RAT MCU fetch stage: PC, ROM address mux, issue FSM and redirects.
// IR is the ROM word paired with IR_PC one cycle after addressing.
module prog_fetch
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] INTR_VEC  = ADDR_W'(INTR_VEC_DEF),
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  prog_fetch_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              stk_err_q, stk_err_d;

  logic              valid;
  logic              redir_go;
  logic              stall_go;
  redir_sel_t        sel;
  logic [ADDR_W-1:0] tgt;
  logic              push, pop;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] ras_dout;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;
  logic              ovf, unf;

  assign valid    = (state_q == ST_RUN);
  assign sel      = redir_sel_t'(bus.REDIR_SEL);
  assign redir_go = valid & bus.REDIR;
  assign stall_go = valid & bus.STALL & ~bus.REDIR;

  assign push = redir_go &
                ((sel == SEL_CALL) | (sel == SEL_INTR));
  assign pop  = redir_go & (sel == SEL_RET);

  // An interrupted instruction has not run, so it is re-fetched on return.
  assign push_data = (sel == SEL_CALL) ?
                     ir_pc_q + ADDR_W'(1) : ir_pc_q;

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (ras_dout),
    .count (ras_cnt),
    .ovf   (ovf),
    .unf   (unf)
  );

  always_comb begin
    tgt = bus.REDIR_ADDR;
    unique case (sel)
      SEL_JUMP: tgt = bus.REDIR_ADDR;
      SEL_CALL: tgt = bus.REDIR_ADDR;
      SEL_RET:  tgt = (ras_cnt == '0) ?
                      RESET_VEC : ras_dout;
      SEL_INTR: tgt = INTR_VEC;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    f_pc_d    = f_pc_q;
    ir_pc_d   = ir_pc_q;
    stk_err_d = stk_err_q | ovf | unf;
    unique case (state_q)
      ST_BOOT, ST_SQUASH: begin
        ir_pc_d = f_pc_q;
        f_pc_d  = f_pc_q + ADDR_W'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.REDIR) begin
          f_pc_d  = tgt;
          state_d = ST_SQUASH;
        end else if (!bus.STALL) begin
          ir_pc_d = f_pc_q;
          f_pc_d  = f_pc_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_BOOT;
      f_pc_q    <= RESET_VEC;
      ir_pc_q   <= '0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_pc_q    <= f_pc_d;
      ir_pc_q   <= ir_pc_d;
      stk_err_q <= stk_err_d;
    end
  end

  // Holding the address on stall makes the ROM re-read the issued word.
  assign bus.PROG_ADDR = stall_go ? ir_pc_q : f_pc_q;
  assign bus.IR        = valid ? bus.PROG_IR : '0;
  assign bus.IR_VALID  = valid;
  assign bus.IR_PC     = ir_pc_q;
  assign bus.RAS_COUNT = ras_cnt;
  assign bus.STK_ERR   = stk_err_q;

endmodule
